// File: rtl/calc_op_controller.sv
`default_nettype none
// ============================================================================
// Module   : calc_op_controller
// Purpose  : Clocked operation controller for the DE10-Lite calculator.
//            Debounces KEY[1:0] into single-cycle press pulses, steps the
//            operation selector, latches switch operands and launches the
//            shared arithmetic/trig datapath with a start/done handshake.
//            Also produces the HEX0-HEX2 blink enable used while selecting.
// Ports    : MAX10_CLK1_50 - system clock (rising edge)
//            resetN        - asynchronous active-low reset
//            KEY[1:0]      - raw active-low buttons (0 select/rerun, 1 commit/exit)
//            SW[9:0]       - operand switches (SW[9] unused)
//            opSel/nsOpSel - current / next operation code
//            opCommit      - high in LAUNCH, WAIT, SHOW
//            opA/opB/opAngle/opCin - latched operands
//            opStart       - one-cycle datapath launch pulse
//            opDone        - datapath completion, sampled only in WAIT
//            busy          - high in LAUNCH and WAIT
//            resultValid   - high in SHOW
//            opError       - high in SHOW after a WAIT timeout
//            blankHex      - blink enable, active only in SELECT
// Options  : define CALC_TIMEOUT_EN to bound WAIT to TIMEOUT_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module calc_op_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic       MAX10_CLK1_50,
  input  logic       resetN,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [2:0] opSel,
  output logic [2:0] nsOpSel,
  output logic       opCommit,
  output logic [3:0] opA,
  output logic [3:0] opB,
  output logic [7:0] opAngle,
  output logic       opCin,
  output logic       opStart,
  input  logic       opDone,
  output logic       busy,
  output logic       resultValid,
  output logic       opError,
  output logic       blankHex
);

  localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_BL_W-1:0] c_BL_MAX = c_BL_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SELECT = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SHOW   = 2'd3
  } calcState_t;

  logic [1:0]  w_press;
  calcState_t  r_state;
  logic        w_unusedSw9;

  assign w_unusedSw9 = SW[9];

  // --------------------------------------------------------------------------
  // Key conditioning: 2-flop synchronizer, stability counter, press pulse.
  // The counter tracks consecutive samples that disagree with the debounced
  // level; any agreeing sample restarts it.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 2; i++) begin : g_key
    logic              r_sync1;
    logic              r_sync2;
    logic              r_deb;
    logic              r_press;
    logic [c_DB_W-1:0] r_cnt;

    always_ff @(posedge MAX10_CLK1_50 or negedge resetN) begin
      if (!resetN) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
        r_deb   <= 1'b1;
        r_press <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= KEY[i];
        r_sync2 <= r_sync1;
        r_press <= 1'b0;
        if (r_sync2 != r_deb) begin
          if (r_cnt == c_DB_MAX) begin
            r_deb   <= r_sync2;
            r_cnt   <= '0;
            // Only the released-to-pressed transition produces a pulse.
            r_press <= ~r_sync2;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    assign w_press[i] = r_press;
  end

  // --------------------------------------------------------------------------
  // Free-running blink generator, independent of the FSM.
  // --------------------------------------------------------------------------
  logic [c_BL_W-1:0] r_blinkCnt;
  logic              r_blink;

  always_ff @(posedge MAX10_CLK1_50 or negedge resetN) begin
    if (!resetN) begin
      r_blinkCnt <= '0;
      r_blink    <= 1'b0;
    end else if (r_blinkCnt == c_BL_MAX) begin
      r_blinkCnt <= '0;
      r_blink    <= ~r_blink;
    end else begin
      r_blinkCnt <= r_blinkCnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Operation FSM. Operands are captured on the same edge that enters LAUNCH,
  // so they are valid alongside opStart. Press1 has priority over press0.
  // --------------------------------------------------------------------------
  logic w_latch;
  assign w_latch = ((r_state == ST_SELECT) && w_press[1]) ||
                   ((r_state == ST_SHOW) && w_press[0] && !w_press[1]);

`ifdef CALC_TIMEOUT_EN
  localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES - 1);
  logic [c_TO_W-1:0] r_waitCnt;
`else
  localparam int c_unusedTimeout = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge MAX10_CLK1_50 or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ST_SELECT;
      opSel       <= 3'd0;
      opA         <= 4'd0;
      opB         <= 4'd0;
      opAngle     <= 8'd0;
      opCin       <= 1'b0;
      opStart     <= 1'b0;
      opCommit    <= 1'b0;
      busy        <= 1'b0;
      resultValid <= 1'b0;
      opError     <= 1'b0;
`ifdef CALC_TIMEOUT_EN
      r_waitCnt   <= '0;
`endif
    end else begin
      opStart <= 1'b0;
      case (r_state)
        ST_SELECT: begin
          if (w_press[1]) begin
            r_state  <= ST_LAUNCH;
            opStart  <= 1'b1;
            opCommit <= 1'b1;
            busy     <= 1'b1;
          end else if (w_press[0]) begin
            opSel <= nsOpSel;
          end
        end
        ST_LAUNCH: begin
          r_state <= ST_WAIT;
`ifdef CALC_TIMEOUT_EN
          r_waitCnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (opDone) begin
            r_state     <= ST_SHOW;
            busy        <= 1'b0;
            resultValid <= 1'b1;
            opError     <= 1'b0;
`ifdef CALC_TIMEOUT_EN
          end else if (r_waitCnt == c_TO_MAX) begin
            r_state     <= ST_SHOW;
            busy        <= 1'b0;
            resultValid <= 1'b1;
            opError     <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
`endif
          end
        end
        ST_SHOW: begin
          if (w_press[1]) begin
            r_state     <= ST_SELECT;
            opCommit    <= 1'b0;
            resultValid <= 1'b0;
            opError     <= 1'b0;
          end else if (w_press[0]) begin
            r_state     <= ST_LAUNCH;
            opStart     <= 1'b1;
            busy        <= 1'b1;
            resultValid <= 1'b0;
            opError     <= 1'b0;
          end
        end
        default: r_state <= ST_SELECT;
      endcase

      if (w_latch) begin
        opA     <= SW[3:0];
        opB     <= SW[7:4];
        opAngle <= SW[7:0];
        // Carry-in is only meaningful for the adder.
        opCin   <= (opSel == 3'd0) ? SW[8] : 1'b0;
      end
    end
  end

  assign nsOpSel  = opSel + 3'd1;
  assign blankHex = r_blink & (r_state == ST_SELECT);

endmodule
`default_nettype wire

// File: tb/tb_calc_op_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_op_controller
// Purpose  : Scoreboard testbench for calc_op_controller. Stimulus pushes
//            expected selector steps, launches and show results into queues;
//            a monitor pops and compares when the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_op_controller;

  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       resetN;
  logic [1:0] KEY;
  logic [9:0] SW;
  logic [2:0] opSel, nsOpSel;
  logic       opCommit, opCin, opStart, opDone, busy, resultValid, opError, blankHex;
  logic [3:0] opA, opB;
  logic [7:0] opAngle;

  always #5 clk = ~clk;

  calc_op_controller #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_CYCLES   (8),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .MAX10_CLK1_50(clk),
    .resetN       (resetN),
    .KEY          (KEY),
    .SW           (SW),
    .opSel        (opSel),
    .nsOpSel      (nsOpSel),
    .opCommit     (opCommit),
    .opA          (opA),
    .opB          (opB),
    .opAngle      (opAngle),
    .opCin        (opCin),
    .opStart      (opStart),
    .opDone       (opDone),
    .busy         (busy),
    .resultValid  (resultValid),
    .opError      (opError),
    .blankHex     (blankHex)
  );

  typedef struct {
    int a;
    int b;
    int ang;
    int cin;
    int sel;
  } launch_t;

  int      total = 0;
  int      bad   = 0;
  int      modelSel = 0;
  launch_t expL[$];
  int      expSel[$];
  int      expErr[$];
  int      prevSel = 0;
  int      prevRv  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!resetN) begin
      prevSel = int'(opSel);
      prevRv  = int'(resultValid);
    end else begin
      chk("nsOpSel", nsOpSel, (int'(opSel) + 1) % 8);
      if (int'(opSel) != prevSel) begin
        if (expSel.size() == 0) chk("unexpectedSelStep", opSel, prevSel);
        else chk("selStep", opSel, expSel.pop_front());
        prevSel = int'(opSel);
      end
      if (opStart) begin
        if (expL.size() == 0) begin
          chk("unexpectedLaunch", opStart, 0);
        end else begin
          launch_t e;
          e = expL.pop_front();
          chk("launchA", opA, e.a);
          chk("launchB", opB, e.b);
          chk("launchAngle", opAngle, e.ang);
          chk("launchCin", opCin, e.cin);
          chk("launchSel", opSel, e.sel);
          chk("launchBusy", busy, 1);
        end
      end
      if (resultValid && prevRv == 0) begin
        if (expErr.size() == 0) chk("unexpectedShow", resultValid, 0);
        else chk("showErr", opError, expErr.pop_front());
      end
      prevRv = int'(resultValid);
    end
  end

  task automatic pushLaunch(input logic [9:0] sw);
    launch_t e;
    e.a   = int'(sw[3:0]);
    e.b   = int'(sw[7:4]);
    e.ang = int'(sw[7:0]);
    e.cin = (modelSel == 0) ? int'(sw[8]) : 0;
    e.sel = modelSel;
    expL.push_back(e);
  endtask

  task automatic pressSel();
    modelSel = (modelSel + 1) % 8;
    expSel.push_back(modelSel);
    KEY[0] = 1'b0;
    repeat (6) @(negedge clk);
    KEY[0] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pressExit();
    KEY[1] = 1'b0;
    repeat (6) @(negedge clk);
    KEY[1] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic waitLaunch(output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (opStart || cyc >= 30) break;
    end
    if (!opStart) chk("launchTimeout", opStart, 1);
  endtask

  initial begin
    int cyc;
    int n;
    logic b0;
    resetN = 1'b1;
    KEY    = 2'b11;
    SW     = '0;
    opDone = 1'b1;
    #2 resetN = 1'b0;
    repeat (3) @(negedge clk);

    chk("rstOpSel", opSel, 0);
    chk("rstNsOpSel", nsOpSel, 1);
    chk("rstOpA", opA, 0);
    chk("rstOpB", opB, 0);
    chk("rstAngle", opAngle, 0);
    chk("rstCin", opCin, 0);
    chk("rstStart", opStart, 0);
    chk("rstCommit", opCommit, 0);
    chk("rstBusy", busy, 0);
    chk("rstValid", resultValid, 0);
    chk("rstError", opError, 0);
    chk("rstBlank", blankHex, 0);
    #2 resetN = 1'b1;
    @(negedge clk);

    // Eight selector steps, wrapping 7 -> 0
    for (int i = 0; i < 8; i++) pressSel();
    chk("wrapSel", opSel, 0);

    // Commit add with SW=13A
    SW = 10'h13A;
    pushLaunch(SW);
    expErr.push_back(0);
    KEY[1] = 1'b0;
    waitLaunch(cyc);
    chk("commitLatency", cyc, 7);
    KEY[1] = 1'b1;
    chk("commitA", opA, 4'hA);
    chk("commitB", opB, 4'h3);
    chk("commitCin", opCin, 1);
    chk("launchCommit", opCommit, 1);
    @(negedge clk);
    chk("waitBusy", busy, 1);
    chk("waitStartLow", opStart, 0);
    chk("waitValidLow", resultValid, 0);
    @(negedge clk);
    chk("showValid", resultValid, 1);
    chk("showBusyLow", busy, 0);
    chk("showCommit", opCommit, 1);
    SW = 10'h2C5;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("showBlankLow", blankHex, 0);
    end
    chk("holdA", opA, 4'hA);
    chk("holdB", opB, 4'h3);
    chk("holdAngle", opAngle, 8'h3A);
    chk("holdCin", opCin, 1);
    pressExit();
    chk("exitValid", resultValid, 0);
    chk("exitCommit", opCommit, 0);
    chk("exitSel", opSel, 0);

    // Blink period in SELECT
    b0 = blankHex;
    n = 0;
    while (blankHex == b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("blinkEdgeSeen", int'(blankHex != b0), 1);
    b0 = blankHex;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk("blinkHold", blankHex, b0);
    end
    @(negedge clk);
    chk("blinkToggle", blankHex, !b0);

    // Short glitch must not step; a real press steps once
    KEY[0] = 1'b0;
    repeat (3) @(negedge clk);
    KEY[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitchNoStep", opSel, 0);
    pressSel();
    chk("holdStepOnce", opSel, 1);
    pressSel();
    pressSel();
    chk("selThree", opSel, 3);

    // Long WAIT, dropped press, late done pulse
    opDone = 1'b0;
    SW = 10'h0F5;
    pushLaunch(SW);
    expErr.push_back(0);
    KEY[1] = 1'b0;
    waitLaunch(cyc);
    KEY[1] = 1'b1;
    for (int w = 1; w <= 10; w++) begin
      @(negedge clk);
      if (w == 1) KEY[0] = 1'b0;
      if (w == 7) KEY[0] = 1'b1;
      chk("longWaitBusy", busy, 1);
      chk("longWaitNoValid", resultValid, 0);
    end
    @(negedge clk);
    chk("longWaitBusy11", busy, 1);
    opDone = 1'b1;
    @(negedge clk);
    opDone = 1'b0;
    chk("showAfterPulse", resultValid, 1);
    chk("droppedPressSel", opSel, 3);
    chk("longA", opA, 4'h5);
    chk("longB", opB, 4'hF);
    chk("longCin", opCin, 0);
    repeat (4) @(negedge clk);

    // Rerun from SHOW with new switches
    SW = 10'h1E7;
    opDone = 1'b1;
    pushLaunch(SW);
    expErr.push_back(0);
    KEY[0] = 1'b0;
    waitLaunch(cyc);
    chk("rerunLatency", cyc, 7);
    KEY[0] = 1'b1;
    chk("rerunA", opA, 4'h7);
    chk("rerunB", opB, 4'hE);
    repeat (2) @(negedge clk);
    chk("rerunShow", resultValid, 1);
    repeat (8) @(negedge clk);
    pressExit();
    chk("rerunExitValid", resultValid, 0);
    chk("rerunExitSel", opSel, 3);

    // Simultaneous presses in SELECT: commit wins
    SW = 10'h155;
    pushLaunch(SW);
    expErr.push_back(0);
    KEY = 2'b00;
    waitLaunch(cyc);
    chk("bothLatency", cyc, 7);
    KEY = 2'b11;
    chk("bothKeepSel", opSel, 3);
    repeat (10) @(negedge clk);
    chk("bothShow", resultValid, 1);
    pressExit();

`ifdef CALC_TIMEOUT_EN
    // Stuck datapath times out
    opDone = 1'b0;
    SW = 10'h1C2;
    pushLaunch(SW);
    expErr.push_back(1);
    KEY[1] = 1'b0;
    waitLaunch(cyc);
    KEY[1] = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (!busy || n >= 100) break;
    end
    chk("timeoutWaitCycles", n - 1, TIMEOUT);
    chk("timeoutValid", resultValid, 1);
    chk("timeoutError", opError, 1);
    repeat (8) @(negedge clk);
    pressExit();
    chk("timeoutExitError", opError, 0);
    chk("timeoutExitValid", resultValid, 0);
`endif

    // Reset in the middle of an operation
    opDone = 1'b0;
    SW = 10'h0AB;
    pushLaunch(SW);
    KEY[1] = 1'b0;
    waitLaunch(cyc);
    KEY[1] = 1'b1;
    #2 resetN = 1'b0;
    #1;
    chk("midRstStart", opStart, 0);
    chk("midRstBusy", busy, 0);
    chk("midRstCommit", opCommit, 0);
    chk("midRstSel", opSel, 0);
    modelSel = 0;
    repeat (2) @(negedge clk);
    #2 resetN = 1'b1;
    repeat (10) @(negedge clk);
    chk("postRstSel", opSel, 0);
    chk("postRstValid", resultValid, 0);

    chk("pendingSel", expSel.size(), 0);
    chk("pendingLaunch", expL.size(), 0);
    chk("pendingShow", expErr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
